// File: rtl/data_mem_pkg.sv
// Shared types and constants for the load/store data memory.
package mem_pkg;

    // Access size, matching funct3[1:0] of RISC-V loads/stores.
    typedef enum logic [1:0] {
        MEM_B = 2'd0,
        MEM_H = 2'd1,
        MEM_W = 2'd2,
        MEM_X = 2'd3
    } mem_size_t;

    // INIT scrubs the array to zero; RUN serves requests.
    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } mem_state_t;

    // Upper bound on the response latency; larger requests are clamped.
    localparam int unsigned MEM_MAX_LATENCY = 4;

    // One response beat as carried down the response pipeline.
    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] rdata;
    } mem_resp_t;

    // Byte-lane enables for a store of the given size at byte offset off.
    function automatic logic [3:0] lane_enables(mem_size_t size, logic [1:0] off);
        logic [3:0] be;
        be = '0;
        unique case (size)
            MEM_B:   be = 4'b0001 << off;
            MEM_H:   be = off[1] ? 4'b1100 : 4'b0011;
            MEM_W:   be = 4'b1111;
            default: be = '0;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/data_mem_if.sv
// Request/response bus between the execute stage and the data memory.
interface data_mem_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    // Requester side (pipeline).
    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    // Memory side.
    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/data_mem_sram_be.sv
// Single-port-style word array with byte-enable writes and a registered read.
module sram_be #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clock,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [31:0] mem [2**ADDR_W];

    // Byte-lane write and registered read; contents are never reset.
    always_ff @(posedge clock) begin
        if (we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/data_mem.sv
// Data memory for the load/store path: byte-lane stores, extended sub-word
// loads, alignment/range errors, post-reset scrub and a configurable
// response latency.
module data_mem
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W         = 10,
    parameter int unsigned LATENCY        = 1,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic       clock,
    input  logic       nreset,
    data_mem_if.slave  bus
);

    localparam int unsigned LAT =
        (LATENCY < 1) ? 1 : ((LATENCY > MEM_MAX_LATENCY) ? MEM_MAX_LATENCY : LATENCY);
    localparam mem_state_t RESET_STATE = CLEAR_ON_RESET ? INIT : RUN;

    mem_state_t        state, state_next;
    logic [ADDR_W-1:0] scrub_ptr, scrub_ptr_next;
    logic              scrub_we;
    logic              ready;

    logic              accept;
    mem_size_t         req_size;
    logic [1:0]        req_off;
    logic [ADDR_W-1:0] req_index;
    logic              range_err;
    logic              align_err;
    logic              req_err;
    logic [3:0]        req_be;
    logic [31:0]       req_lane_data;

    logic              sram_we;
    logic              sram_re;
    logic [3:0]        sram_be;
    logic [ADDR_W-1:0] sram_waddr;
    logic [31:0]       sram_wdata;
    logic [31:0]       sram_rdata;

    logic              s1_valid;
    logic              s1_err;
    logic              s1_load;
    mem_size_t         s1_size;
    logic              s1_unsigned;
    logic [1:0]        s1_off;
    logic [15:0]       lane_half;
    logic [7:0]        lane_byte;
    logic [31:0]       load_ext;
    mem_resp_t         s1_resp;
    mem_resp_t         resp_out;

    // State register and scrub pointer; reset restarts the scrub at word 0.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state     <= RESET_STATE;
            scrub_ptr <= '0;
        end else begin
            state     <= state_next;
            scrub_ptr <= scrub_ptr_next;
        end
    end

    // Next state, scrub walk and request readiness.
    always_comb begin
        state_next     = state;
        scrub_ptr_next = scrub_ptr;
        scrub_we       = 1'b0;
        ready          = 1'b0;
        unique case (state)
            INIT: begin
                scrub_we       = 1'b1;
                scrub_ptr_next = scrub_ptr + ADDR_W'(1);
                if (scrub_ptr == '1) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                ready = 1'b1;
            end
            default: state_next = RUN;
        endcase
    end

    assign accept    = bus.req_valid && ready;
    assign req_size  = mem_size_t'(bus.req_size);
    assign req_off   = bus.req_addr[1:0];
    assign req_index = bus.req_addr[ADDR_W+1:2];

    // Request decode: error detection, store lane enables and lane-replicated data.
    always_comb begin
        range_err     = (bus.req_addr >> (ADDR_W + 2)) != '0;
        align_err     = 1'b0;
        req_lane_data = bus.req_wdata;
        unique case (req_size)
            MEM_B: req_lane_data = {4{bus.req_wdata[7:0]}};
            MEM_H: begin
                align_err     = req_off[0];
                req_lane_data = {2{bus.req_wdata[15:0]}};
            end
            MEM_W: align_err = (req_off != 2'b00);
            default: align_err = 1'b1;
        endcase
        req_err = range_err || align_err;
        req_be  = lane_enables(req_size, req_off);
    end

    // Array port mux: the scrub owns the write port during INIT.
    always_comb begin
        sram_we    = 1'b0;
        sram_be    = req_be;
        sram_waddr = req_index;
        sram_wdata = req_lane_data;
        sram_re    = 1'b0;
        if (scrub_we) begin
            sram_we    = 1'b1;
            sram_be    = '1;
            sram_waddr = scrub_ptr;
            sram_wdata = '0;
        end else begin
            sram_we = accept && bus.req_we && !req_err;
            sram_re = accept && !bus.req_we && !req_err;
        end
    end

    sram_be #(
        .ADDR_W(ADDR_W)
    ) u_sram (
        .clock (clock),
        .we    (sram_we),
        .be    (sram_be),
        .waddr (sram_waddr),
        .wdata (sram_wdata),
        .re    (sram_re),
        .raddr (req_index),
        .rdata (sram_rdata)
    );

    // First response stage: request attributes aligned with the registered read.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            s1_valid    <= 1'b0;
            s1_err      <= 1'b0;
            s1_load     <= 1'b0;
            s1_size     <= MEM_B;
            s1_unsigned <= 1'b0;
            s1_off      <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_err      <= req_err;
                s1_load     <= !bus.req_we && !req_err;
                s1_size     <= req_size;
                s1_unsigned <= bus.req_unsigned;
                s1_off      <= req_off;
            end
        end
    end

    // Lane select and sign/zero extension of the read word.
    always_comb begin
        lane_half = s1_off[1] ? sram_rdata[31:16] : sram_rdata[15:0];
        lane_byte = s1_off[0] ? lane_half[15:8] : lane_half[7:0];
        load_ext  = '0;
        unique case (s1_size)
            MEM_B:   load_ext = s1_unsigned ? {24'h0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
            MEM_H:   load_ext = s1_unsigned ? {16'h0, lane_half} : {{16{lane_half[15]}}, lane_half};
            MEM_W:   load_ext = sram_rdata;
            default: load_ext = '0;
        endcase
        s1_resp.valid = s1_valid;
        s1_resp.err   = s1_valid && s1_err;
        s1_resp.rdata = (s1_valid && s1_load) ? load_ext : '0;
    end

    // Stage one is the array's own read register, so only LAT-1 extra
    // registers are needed to reach the configured latency.
    generate
        if (LAT == 1) begin : g_direct
            assign resp_out = s1_resp;
        end else begin : g_pipe
            mem_resp_t pipe [LAT-1];

            // Response delay line; reset drops every in-flight response.
            always_ff @(posedge clock or negedge nreset) begin
                if (!nreset) begin
                    for (int unsigned i = 0; i < LAT - 1; i++) begin
                        pipe[i] <= '0;
                    end
                end else begin
                    pipe[0] <= s1_resp;
                    for (int unsigned i = 1; i < LAT - 1; i++) begin
                        pipe[i] <= pipe[i-1];
                    end
                end
            end

            assign resp_out = pipe[LAT-2];
        end
    endgenerate

    assign bus.req_ready  = ready;
    assign bus.resp_valid = resp_out.valid;
    assign bus.resp_err   = resp_out.err;
    assign bus.resp_rdata = resp_out.rdata;

endmodule

// File: tb/tb_data_mem.sv
// Directed bench for data_mem: two instances (latency 1 and 3) see the same
// request stream; each response is matched against a per-instance scoreboard
// that also enforces the cycle on which it must appear.
module tb_data_mem;
    import mem_pkg::*;

    localparam int unsigned AW = 4;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic        clock = 1'b0;
    logic        nreset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    vec_t vecs[$];
    exp_t q[2][$];

    data_mem_if bus_a ();
    data_mem_if bus_b ();

    assign bus_a.req_valid    = req_valid;
    assign bus_a.req_we       = req_we;
    assign bus_a.req_size     = req_size;
    assign bus_a.req_unsigned = req_unsigned;
    assign bus_a.req_addr     = req_addr;
    assign bus_a.req_wdata    = req_wdata;
    assign bus_b.req_valid    = req_valid;
    assign bus_b.req_we       = req_we;
    assign bus_b.req_size     = req_size;
    assign bus_b.req_unsigned = req_unsigned;
    assign bus_b.req_addr     = req_addr;
    assign bus_b.req_wdata    = req_wdata;

    data_mem #(.ADDR_W(AW), .LATENCY(1), .CLEAR_ON_RESET(1'b1)) dut_a (
        .clock(clock), .nreset(nreset), .bus(bus_a)
    );
    data_mem #(.ADDR_W(AW), .LATENCY(3), .CLEAR_ON_RESET(1'b1)) dut_b (
        .clock(clock), .nreset(nreset), .bus(bus_b)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic int lat_of(int k);
        return (k == 0) ? 1 : 3;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Compare one instance's response port against its scoreboard head.
    task automatic mon(int k, string tag, logic v, logic e, logic [31:0] d);
        exp_t x;
        if (q[k].size() > 0 && q[k][0].due == cyc) begin
            x = q[k].pop_front();
            check({tag, ".resp_valid"}, v, 1);
            check({tag, ".resp_err"}, e, x.err);
            check({tag, ".resp_rdata"}, d, x.rdata);
        end else begin
            check({tag, ".resp_valid_idle"}, v, 0);
        end
    endtask

    always @(negedge clock) begin
        mon(0, "L1", bus_a.resp_valid, bus_a.resp_err, bus_a.resp_rdata);
        mon(1, "L3", bus_b.resp_valid, bus_b.resp_err, bus_b.resp_rdata);
    end

    function automatic void add(logic we, logic [1:0] size, logic uns, logic [31:0] addr,
                                logic [31:0] wdata, logic err, logic [31:0] rdata);
        vec_t v;
        v.we = we; v.size = size; v.uns = uns; v.addr = addr;
        v.wdata = wdata; v.err = err; v.rdata = rdata;
        vecs.push_back(v);
    endfunction

    // Drive one request, let it be accepted, then record expected responses.
    task automatic send(vec_t v);
        exp_t x;
        req_valid    = 1'b1;
        req_we       = v.we;
        req_size     = v.size;
        req_unsigned = v.uns;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
        check("L1.req_ready", bus_a.req_ready, 1);
        check("L3.req_ready", bus_b.req_ready, 1);
        @(posedge clock);
        #1;
        for (int k = 0; k < 2; k++) begin
            x.due   = cyc + lat_of(k) - 1;
            x.err   = v.err;
            x.rdata = v.rdata;
            q[k].push_back(x);
        end
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    // Called just after nreset deasserts: 16 cycles not ready, then ready.
    task automatic scrub_check(string tag);
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            check({tag, ".L1.scrub_ready_low"}, bus_a.req_ready, 0);
            check({tag, ".L3.scrub_ready_low"}, bus_b.req_ready, 0);
        end
        @(negedge clock);
        check({tag, ".L1.scrub_ready_high"}, bus_a.req_ready, 1);
        check({tag, ".L3.scrub_ready_high"}, bus_b.req_ready, 1);
    endtask

    task automatic drain(string tag);
        repeat (5) @(negedge clock);
        check({tag, ".L1.pending"}, q[0].size(), 0);
        check({tag, ".L3.pending"}, q[1].size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        // we size uns addr wdata err rdata
        add(0, 2, 0, 32'h3C,   32'h0,        0, 32'h0000_0000);
        add(1, 2, 0, 32'h08,   32'hDEADBEEF, 0, 32'h0000_0000);
        add(0, 2, 0, 32'h08,   32'h0,        0, 32'hDEADBEEF);
        add(1, 0, 0, 32'h09,   32'h12345680, 0, 32'h0000_0000);
        add(0, 2, 0, 32'h08,   32'h0,        0, 32'hDEAD80EF);
        add(0, 0, 0, 32'h09,   32'h0,        0, 32'hFFFFFF80);
        add(0, 0, 1, 32'h09,   32'h0,        0, 32'h0000_0080);
        add(1, 2, 0, 32'h04,   32'h11223344, 0, 32'h0000_0000);
        add(0, 1, 0, 32'h03,   32'h0,        1, 32'h0000_0000);
        add(1, 2, 0, 32'h06,   32'h55555555, 1, 32'h0000_0000);
        add(0, 2, 0, 32'h40,   32'h0,        1, 32'h0000_0000);
        add(0, 2, 0, 32'h04,   32'h0,        0, 32'h11223344);
        add(0, 0, 0, 32'h04,   32'h0,        0, 32'h0000_0044);
        add(0, 0, 0, 32'h07,   32'h0,        0, 32'h0000_0011);
        add(0, 1, 1, 32'h06,   32'h0,        0, 32'h0000_1122);
        add(0, 1, 0, 32'h06,   32'h0,        0, 32'h0000_1122);
        add(1, 1, 0, 32'h0A,   32'hFFFF9876, 0, 32'h0000_0000);
        add(0, 1, 0, 32'h0A,   32'h0,        0, 32'hFFFF9876);
        add(0, 1, 1, 32'h0A,   32'h0,        0, 32'h0000_9876);
        add(0, 1, 0, 32'h08,   32'h0,        0, 32'hFFFF80EF);
        add(0, 0, 0, 32'h0B,   32'h0,        0, 32'hFFFFFF98);
        add(0, 0, 1, 32'h08,   32'h0,        0, 32'h0000_00EF);
        add(0, 3, 0, 32'h00,   32'h0,        1, 32'h0000_0000);
        add(1, 3, 0, 32'h08,   32'h0,        1, 32'h0000_0000);
        add(0, 2, 0, 32'h08,   32'h0,        0, 32'h987680EF);
        add(1, 2, 0, 32'h1000, 32'hFFFFFFFF, 1, 32'h0000_0000);
        add(0, 2, 0, 32'h00,   32'h0,        0, 32'h0000_0000);
        add(0, 2, 1, 32'h08,   32'h0,        0, 32'h987680EF);
        add(1, 0, 0, 32'h3F,   32'h000000AA, 0, 32'h0000_0000);
        add(0, 0, 0, 32'h3F,   32'h0,        0, 32'hFFFFFFAA);
        add(0, 2, 0, 32'h3C,   32'h0,        0, 32'hAA000000);

        // Reset values while nreset is held low.
        repeat (3) @(negedge clock);
        check("L1.reset_ready", bus_a.req_ready, 0);
        check("L3.reset_ready", bus_b.req_ready, 0);
        check("L1.reset_resp_valid", bus_a.resp_valid, 0);
        check("L3.reset_resp_valid", bus_b.resp_valid, 0);
        check("L1.reset_rdata", bus_a.resp_rdata, 0);
        check("L3.reset_rdata", bus_b.resp_rdata, 0);
        check("L1.reset_err", bus_a.resp_err, 0);
        check("L3.reset_err", bus_b.resp_err, 0);

        // Reset part-way through the scrub restarts the full 16-cycle walk.
        @(posedge clock); #1 nreset = 1'b1;
        repeat (5) @(negedge clock);
        @(posedge clock); #1 nreset = 1'b0;
        @(negedge clock);
        check("L1.rescrub_ready", bus_a.req_ready, 0);
        @(posedge clock); #1 nreset = 1'b1;
        scrub_check("scrub");

        // Table: back-to-back requests through both latencies.
        foreach (vecs[i]) send(vecs[i]);
        idle();
        drain("table");

        // Reset with two loads in flight: responses vanish, scrub reruns.
        v = vecs[2];
        v.rdata = 32'h987680EF;
        send(v);
        v.addr = 32'h3C;
        v.rdata = 32'hAA000000;
        send(v);
        nreset = 1'b0;
        q[0].delete();
        q[1].delete();
        idle();
        #1;
        check("L1.midreset_resp_valid", bus_a.resp_valid, 0);
        check("L3.midreset_resp_valid", bus_b.resp_valid, 0);
        check("L1.midreset_ready", bus_a.req_ready, 0);
        repeat (2) @(negedge clock);
        @(posedge clock); #1 nreset = 1'b1;
        scrub_check("rescrub");

        // The scrub cleared words written before the reset.
        v.addr = 32'h08;
        v.rdata = 32'h0;
        send(v);
        v.addr = 32'h3C;
        send(v);
        idle();
        drain("post");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
